// File: rtl/brainhack_pkg.sv
// Shared opcode encodings, FSM state set and instruction width for brainhack_core.
package brainhack_pkg;

   localparam int unsigned INSN_W = 3;

   localparam logic [INSN_W-1:0] OP_OUT   = 3'b000;
   localparam logic [INSN_W-1:0] OP_IN    = 3'b001;
   localparam logic [INSN_W-1:0] OP_INC   = 3'b010;
   localparam logic [INSN_W-1:0] OP_DEC   = 3'b011;
   localparam logic [INSN_W-1:0] OP_RIGHT = 3'b100;
   localparam logic [INSN_W-1:0] OP_LEFT  = 3'b101;
   localparam logic [INSN_W-1:0] OP_OPEN  = 3'b110;
   localparam logic [INSN_W-1:0] OP_CLOSE = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_OUT,
      ST_IN,
      ST_SKIP,
      ST_DONE,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/inc_dec.sv
// Modulo-2^W increment/decrement used for tape pointer, cell value and stack pointer.
module inc_dec #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] value,
   input  logic         dec,
   output logic [W-1:0] result
);

   // wrap-around step in either direction
   assign result = dec ? (value - W'(1)) : (value + W'(1));

endmodule

// File: rtl/brainhack_core.sv
// Multi-cycle Brainfuck processor with external program memory, tape and bracket stack.
// Optional BRAINHACK_IO_EN enables the '.'/',' stream handshakes; otherwise they are NOPs.
module brainhack_core
   import brainhack_pkg::*;
#(
   parameter int unsigned TAPE_DW  = 8,
   parameter int unsigned TAPE_AW  = 8,
   parameter int unsigned PRG_AW   = 8,
   parameter int unsigned STACK_AW = 4
) (
   input  logic                i_clock,
   input  logic                i_reset_n,
   input  logic                i_start,
   input  logic [PRG_AW-1:0]   i_prg_len,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_error,
   output logic [PRG_AW-1:0]   o_prgmem_addr,
   input  logic [INSN_W-1:0]   i_prgmem_data,
   output logic [TAPE_AW-1:0]  o_tape_addr,
   output logic                o_tape_we,
   output logic [TAPE_DW-1:0]  o_tape_data,
   input  logic [TAPE_DW-1:0]  i_tape_data,
   output logic [STACK_AW-1:0] o_stack_addr,
   output logic                o_stack_we,
   output logic [PRG_AW-1:0]   o_stack_data,
   input  logic [PRG_AW-1:0]   i_stack_data,
   output logic                o_out_valid,
   output logic [TAPE_DW-1:0]  o_out_data,
   input  logic                i_out_ready,
   output logic                o_in_ready,
   input  logic                i_in_valid,
   input  logic [TAPE_DW-1:0]  i_in_data
);

   state_t               state, state_d;
   logic [PRG_AW-1:0]    pc, pc_d, pc_inc;
   logic [PRG_AW-1:0]    depth, depth_d;
   logic [TAPE_AW-1:0]   ptr, ptr_d, ptr_step;
   logic [STACK_AW-1:0]  sp, sp_d, sp_step;
   logic [INSN_W-1:0]    ir, ir_d;
   logic [TAPE_DW-1:0]   cell_step;
   logic                 cell_zero, stack_full, stack_empty;
`ifdef BRAINHACK_IO_EN
   logic [TAPE_DW-1:0]   out_data, out_data_d;
`endif

   assign pc_inc      = pc + PRG_AW'(1);
   assign cell_zero   = (i_tape_data == '0);
   assign stack_full  = (sp == {STACK_AW{1'b1}});
   assign stack_empty = (sp == '0);

   inc_dec #(.W(TAPE_AW))  u_ptr  (.value(ptr),         .dec(ir == OP_LEFT),  .result(ptr_step));
   inc_dec #(.W(TAPE_DW))  u_cell (.value(i_tape_data), .dec(ir == OP_DEC),   .result(cell_step));
   inc_dec #(.W(STACK_AW)) u_sp   (.value(sp),          .dec(ir == OP_CLOSE), .result(sp_step));

   // state and architectural registers
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state    <= ST_IDLE;
         pc       <= '0;
         depth    <= '0;
         ptr      <= '0;
         sp       <= '0;
         ir       <= '0;
`ifdef BRAINHACK_IO_EN
         out_data <= '0;
`endif
      end else begin
         state    <= state_d;
         pc       <= pc_d;
         depth    <= depth_d;
         ptr      <= ptr_d;
         sp       <= sp_d;
         ir       <= ir_d;
`ifdef BRAINHACK_IO_EN
         out_data <= out_data_d;
`endif
      end
   end

   // next-state, register updates and combinational memory write strobes
   always_comb begin
      state_d      = state;
      pc_d         = pc;
      depth_d      = depth;
      ptr_d        = ptr;
      sp_d         = sp;
      ir_d         = ir;
      o_tape_we    = 1'b0;
      o_tape_data  = '0;
      o_stack_we   = 1'b0;
      o_stack_data = '0;
      o_stack_addr = sp;
`ifdef BRAINHACK_IO_EN
      out_data_d   = out_data;
`endif
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (i_start) begin
               pc_d    = '0;
               ptr_d   = '0;
               sp_d    = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (pc == i_prg_len) begin
               state_d = ST_DONE;
            end else begin
               ir_d    = i_prgmem_data;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
            case (ir)
               OP_INC, OP_DEC: begin
                  o_tape_we   = 1'b1;
                  o_tape_data = cell_step;
               end
               OP_RIGHT, OP_LEFT: ptr_d = ptr_step;
               OP_OPEN: begin
                  if (cell_zero) begin
                     depth_d = PRG_AW'(1);
                     state_d = ST_SKIP;
                  end else if (stack_full) begin
                     pc_d    = pc;
                     state_d = ST_ERROR;
                  end else begin
                     o_stack_we   = 1'b1;
                     o_stack_data = pc_inc;
                     sp_d         = sp_step;
                  end
               end
               OP_CLOSE: begin
                  o_stack_addr = sp_step;
                  if (stack_empty) begin
                     pc_d    = pc;
                     state_d = ST_ERROR;
                  end else if (!cell_zero) begin
                     pc_d = i_stack_data;
                  end else begin
                     sp_d = sp_step;
                  end
               end
`ifdef BRAINHACK_IO_EN
               OP_OUT: begin
                  out_data_d = i_tape_data;
                  pc_d       = pc;
                  state_d    = ST_OUT;
               end
               OP_IN: begin
                  pc_d    = pc;
                  state_d = ST_IN;
               end
`endif
               default: ;
            endcase
         end
`ifdef BRAINHACK_IO_EN
         ST_OUT: begin
            if (i_out_ready) begin
               pc_d    = pc_inc;
               state_d = ST_FETCH;
            end
         end
         ST_IN: begin
            if (i_in_valid) begin
               o_tape_we   = 1'b1;
               o_tape_data = i_in_data;
               pc_d        = pc_inc;
               state_d     = ST_FETCH;
            end
         end
`endif
         ST_SKIP: begin
            if (pc == i_prg_len) begin
               state_d = ST_ERROR;
            end else begin
               pc_d = pc_inc;
               if (i_prgmem_data == OP_OPEN) begin
                  depth_d = depth + PRG_AW'(1);
               end else if (i_prgmem_data == OP_CLOSE) begin
                  depth_d = depth - PRG_AW'(1);
                  if (depth == PRG_AW'(1)) state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_busy        = state inside {ST_FETCH, ST_EXEC, ST_OUT, ST_IN, ST_SKIP};
   assign o_done        = (state == ST_DONE);
   assign o_error       = (state == ST_ERROR);
   assign o_prgmem_addr = pc;
   assign o_tape_addr   = ptr;

`ifdef BRAINHACK_IO_EN
   assign o_out_valid = (state == ST_OUT);
   assign o_out_data  = out_data;
   assign o_in_ready  = (state == ST_IN);
`else
   logic unused_io;
   assign unused_io   = ^{i_out_ready, i_in_valid, i_in_data};
   assign o_out_valid = 1'b0;
   assign o_out_data  = '0;
   assign o_in_ready  = 1'b0;
`endif

endmodule

// File: tb/tb_brainhack_core.sv
// Scoreboard bench for brainhack_core: expected tape/stack writes, output beats and halts are
// queued by the stimulus, and a monitor process compares them as the DUT presents them.
module tb_brainhack_core;

   localparam int unsigned TAPE_DW  = 8;
   localparam int unsigned TAPE_AW  = 8;
   localparam int unsigned PRG_AW   = 8;
   localparam int unsigned STACK_AW = 4;

   localparam logic [1:0] K_TAPE  = 2'd0;
   localparam logic [1:0] K_STACK = 2'd1;
   localparam logic [1:0] K_OUT   = 2'd2;
   localparam logic [1:0] K_HALT  = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] addr;
      logic [7:0] data;
   } ev_t;

   logic                i_clock = 1'b0;
   logic                i_reset_n;
   logic                i_start;
   logic [PRG_AW-1:0]   i_prg_len;
   logic                o_busy, o_done, o_error;
   logic [PRG_AW-1:0]   o_prgmem_addr;
   logic [2:0]          i_prgmem_data;
   logic [TAPE_AW-1:0]  o_tape_addr;
   logic                o_tape_we;
   logic [TAPE_DW-1:0]  o_tape_data, i_tape_data;
   logic [STACK_AW-1:0] o_stack_addr;
   logic                o_stack_we;
   logic [PRG_AW-1:0]   o_stack_data, i_stack_data;
   logic                o_out_valid;
   logic [TAPE_DW-1:0]  o_out_data;
   logic                i_out_ready;
   logic                o_in_ready;
   logic                i_in_valid;
   logic [TAPE_DW-1:0]  i_in_data;

   logic [2:0] prg   [256];
   logic [7:0] tape  [256];
   logic [7:0] stack [16];

   ev_t sb_q[$];
   int  n_checks = 0;
   int  n_fails  = 0;
   int  cyc;

   always #5 i_clock = ~i_clock;

   assign i_prgmem_data = prg[o_prgmem_addr];
   assign i_tape_data   = tape[o_tape_addr];
   assign i_stack_data  = stack[o_stack_addr];

   brainhack_core #(
      .TAPE_DW(TAPE_DW), .TAPE_AW(TAPE_AW), .PRG_AW(PRG_AW), .STACK_AW(STACK_AW)
   ) dut (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .i_start(i_start), .i_prg_len(i_prg_len),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .o_prgmem_addr(o_prgmem_addr), .i_prgmem_data(i_prgmem_data),
      .o_tape_addr(o_tape_addr), .o_tape_we(o_tape_we), .o_tape_data(o_tape_data),
      .i_tape_data(i_tape_data),
      .o_stack_addr(o_stack_addr), .o_stack_we(o_stack_we), .o_stack_data(o_stack_data),
      .i_stack_data(i_stack_data),
      .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready),
      .o_in_ready(o_in_ready), .i_in_valid(i_in_valid), .i_in_data(i_in_data)
   );

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic ev_t mk(logic [1:0] kind, logic [7:0] addr, logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      return e;
   endfunction

   function automatic void push(logic [1:0] kind, logic [7:0] addr, logic [7:0] data);
      sb_q.push_back(mk(kind, addr, data));
   endfunction

   function automatic void expect_ev(ev_t act);
      ev_t exp;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fails++;
         $display("FAIL sb_unexpected: got 0x%0h, expected no event", act);
      end else begin
         exp = sb_q.pop_front();
         chk("sb_event", 64'(act), 64'(exp));
      end
   endfunction

   function automatic logic [63:0] all_outs();
      return 64'({o_busy, o_done, o_error, o_tape_we, o_stack_we, o_out_valid, o_in_ready,
                  o_prgmem_addr, o_tape_addr, o_tape_data, o_stack_addr, o_stack_data,
                  o_out_data});
   endfunction

   function automatic logic [2:0] op(byte c);
      case (c)
         ".":     return 3'b000;
         ",":     return 3'b001;
         "+":     return 3'b010;
         "-":     return 3'b011;
         ">":     return 3'b100;
         "<":     return 3'b101;
         "[":     return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   task automatic load_prog(input string s);
      for (int i = 0; i < s.len(); i++) prg[i] = op(s[i]);
      i_prg_len = PRG_AW'(s.len());
   endtask

   // external memories: writes commit on the rising edge
   task automatic mem_loop();
      forever begin
         @(posedge i_clock);
         if (o_tape_we)  tape[o_tape_addr]   <= o_tape_data;
         if (o_stack_we) stack[o_stack_addr] <= o_stack_data;
      end
   endtask

   // compares every DUT-presented event against the head of the scoreboard
   task automatic monitor();
      logic [1:0] prev_halt = 2'b00;
      logic [1:0] halt;
      forever begin
         @(negedge i_clock);
         halt = {o_error, o_done};
         if (o_tape_we)  expect_ev(mk(K_TAPE, o_tape_addr, o_tape_data));
         if (o_stack_we) expect_ev(mk(K_STACK, 8'(o_stack_addr), o_stack_data));
         if (o_out_valid && i_out_ready) expect_ev(mk(K_OUT, 8'h00, o_out_data));
         if (halt != prev_halt && halt != 2'b00) expect_ev(mk(K_HALT, 8'h00, 8'(halt)));
         prev_halt = halt;
      end
   endtask

   task automatic start_run();
      i_start = 1'b1;
      @(posedge i_clock); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_halt(input int max, input int c0, output int c);
      c = c0;
      while (!(o_done || o_error) && c < max) begin
         @(posedge i_clock); #1;
         c++;
      end
      chk("halt_reached", 64'(o_done | o_error), 64'd1);
   endtask

   task automatic drain(input string name);
      repeat (2) begin
         @(posedge i_clock); #1;
      end
      chk(name, 64'(sb_q.size()), 64'd0);
      sb_q.delete();
   endtask

   initial begin
      i_reset_n   = 1'b0;
      i_start     = 1'b0;
      i_prg_len   = '0;
      i_out_ready = 1'b1;
      i_in_valid  = 1'b0;
      i_in_data   = '0;
      for (int i = 0; i < 256; i++) begin
         prg[i]  = 3'b000;
         tape[i] <= 8'h00;
      end
      for (int i = 0; i < 16; i++) stack[i] <= 8'h00;
      fork
         monitor();
         mem_loop();
      join_none

      repeat (2) @(posedge i_clock);
      #1;
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_all_outputs", all_outs(), 64'd0);
      i_reset_n = 1'b1;
      @(posedge i_clock); #1;
      chk("idle_no_start", 64'(o_busy), 64'd0);

      // "+++" from cell 0; a second start while busy must be ignored
      load_prog("+++");
      tape[0] <= 8'h00;
      push(K_TAPE, 8'h00, 8'h01);
      push(K_TAPE, 8'h00, 8'h02);
      push(K_TAPE, 8'h00, 8'h03);
      push(K_HALT, 8'h00, 8'h01);
      start_run();
      chk("busy_after_start", 64'(o_busy), 64'd1);
      i_start = 1'b1;
      @(posedge i_clock); #1;
      i_start = 1'b0;
      wait_halt(100, 2, cyc);
      chk("inc3_cycles", 64'(cyc), 64'd8);
      chk("inc3_error", 64'(o_error), 64'd0);
      drain("inc3_sb_drained");
      chk("inc3_tape0", 64'(tape[0]), 64'h03);

      // "-<-": cell underflow to 0xFF, pointer wraps to 0xFF
      load_prog("-<-");
      tape[0]   <= 8'h00;
      tape[255] <= 8'h05;
      push(K_TAPE, 8'h00, 8'hFF);
      push(K_TAPE, 8'hFF, 8'h04);
      push(K_HALT, 8'h00, 8'h01);
      start_run();
      wait_halt(100, 1, cyc);
      chk("wrap_ptr", 64'(o_tape_addr), 64'hFF);
      drain("wrap_sb_drained");

      // "[-]" with cell 3: loop runs down to zero and pops the stack
      load_prog("[-]");
      tape[0] <= 8'h03;
      push(K_STACK, 8'h00, 8'h01);
      push(K_TAPE, 8'h00, 8'h02);
      push(K_TAPE, 8'h00, 8'h01);
      push(K_TAPE, 8'h00, 8'h00);
      push(K_HALT, 8'h00, 8'h01);
      start_run();
      wait_halt(200, 1, cyc);
      chk("loop_error", 64'(o_error), 64'd0);
      chk("loop_sp_zero", 64'(o_stack_addr), 64'd0);
      drain("loop_sb_drained");
      chk("loop_tape0", 64'(tape[0]), 64'h00);

      // "[+[+]+]" with cell 0: whole body skipped, no writes at all
      load_prog("[+[+]+]");
      push(K_HALT, 8'h00, 8'h01);
      start_run();
      wait_halt(100, 1, cyc);
      chk("skip_cycles", 64'(cyc), 64'd10);
      drain("skip_sb_drained");

`ifdef BRAINHACK_IO_EN
      // ",." with a late input and an output held for five cycles
      load_prog(",.");
      i_out_ready = 1'b0;
      push(K_TAPE, 8'h00, 8'h41);
      push(K_OUT, 8'h00, 8'h41);
      push(K_HALT, 8'h00, 8'h01);
      start_run();
      cyc = 0;
      while (!o_in_ready && cyc < 20) begin
         @(posedge i_clock); #1;
         cyc++;
      end
      chk("io_in_ready", 64'(o_in_ready), 64'd1);
      repeat (2) begin
         @(posedge i_clock); #1;
      end
      chk("io_in_ready_held", 64'(o_in_ready), 64'd1);
      i_in_valid = 1'b1;
      i_in_data  = 8'h41;
      @(posedge i_clock); #1;
      i_in_valid = 1'b0;
      i_in_data  = 8'h00;
      cyc = 0;
      while (!o_out_valid && cyc < 20) begin
         @(posedge i_clock); #1;
         cyc++;
      end
      for (int k = 0; k < 5; k++) begin
         chk("io_out_valid_held", 64'(o_out_valid), 64'd1);
         chk("io_out_data_stable", 64'(o_out_data), 64'h41);
         @(posedge i_clock); #1;
      end
      i_out_ready = 1'b1;
      wait_halt(50, 1, cyc);
      drain("io_sb_drained");
`else
      // ",." without stream support: two NOPs
      load_prog(",.");
      push(K_HALT, 8'h00, 8'h01);
      start_run();
      wait_halt(100, 1, cyc);
      chk("nop_io_cycles", 64'(cyc), 64'd6);
      chk("nop_io_flags", 64'({o_out_valid, o_in_ready}), 64'd0);
      drain("nop_io_sb_drained");
`endif

      // "]" first: stack underflow, no stack write
      load_prog("]");
      push(K_HALT, 8'h00, 8'h02);
      start_run();
      wait_halt(100, 1, cyc);
      chk("underflow_error", 64'(o_error), 64'd1);
      chk("underflow_done", 64'(o_done), 64'd0);
      drain("underflow_sb_drained");

      // sixteen nested "[" on a nonzero cell: the sixteenth overflows
      load_prog("[[[[[[[[[[[[[[[[");
      tape[0] <= 8'h01;
      for (int i = 0; i < 15; i++) push(K_STACK, 8'(i), 8'(i + 1));
      push(K_HALT, 8'h00, 8'h02);
      start_run();
      wait_halt(200, 1, cyc);
      chk("overflow_error", 64'(o_error), 64'd1);
      drain("overflow_sb_drained");
      chk("overflow_stack14", 64'(stack[14]), 64'd15);

      // reset asserted while a tape write is pending
      load_prog("[+]");
      tape[0] <= 8'h01;
      push(K_STACK, 8'h00, 8'h01);
      start_run();
      repeat (3) begin
         @(posedge i_clock); #1;
      end
      chk("midrun_we", 64'(o_tape_we), 64'd1);
      chk("midrun_data", 64'(o_tape_data), 64'h02);
      #1 i_reset_n = 1'b0;
      #1 chk("midrun_rst_outputs", all_outs(), 64'd0);
      @(posedge i_clock); #1;
      chk("midrun_no_commit", 64'(tape[0]), 64'h01);
      i_reset_n = 1'b1;
      drain("midrun_sb_drained");

      // recovery after reset
      load_prog("+");
      push(K_TAPE, 8'h00, 8'h02);
      push(K_HALT, 8'h00, 8'h01);
      start_run();
      wait_halt(100, 1, cyc);
      chk("recover_cycles", 64'(cyc), 64'd4);
      drain("recover_sb_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/brainhack_core.md
# brainhack_core

Parametrised successor to the two-phase Brainfuck datapath: a multi-cycle Brainfuck processor with the full eight-instruction set. It adds `.`/`,` I/O over valid/ready handshakes, start/done control, a bracket-skip mode that does not touch the stack, and stack overflow/underflow detection. Program memory, tape and bracket stack are external: combinational read, write on the rising clock edge.

## Interface
- TAPE_DW, 8, tape cell width
- TAPE_AW, 8, tape address width; tape length is 2^TAPE_AW
- PRG_AW, 8, program address width
- STACK_AW, 4, stack address width; depth is 2^STACK_AW
- i_clock  in  1  sole clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; ignored while o_busy
- i_prg_len  in  PRG_AW  program length; execution halts when pc == i_prg_len
- o_busy / o_done / o_error  out  1 each  running / halted normally / halted on error
- o_prgmem_addr  out  PRG_AW; i_prgmem_data  in  3  program fetch
- o_tape_addr  out  TAPE_AW; o_tape_we  out  1; o_tape_data  out  TAPE_DW; i_tape_data  in  TAPE_DW
- o_stack_addr  out  STACK_AW; o_stack_we  out  1; o_stack_data  out  PRG_AW; i_stack_data  in  PRG_AW
- o_out_valid  out  1; o_out_data  out  TAPE_DW; i_out_ready  in  1  output stream
- o_in_ready  out  1; i_in_valid  in  1; i_in_data  in  TAPE_DW  input stream

## Operation
- Opcodes: 000 `.`, 001 `,`, 010 `+`, 011 `-`, 100 `>`, 101 `<`, 110 `[`, 111 `]`.
- States: IDLE, FETCH, EXEC, OUT, IN, SKIP, DONE, ERROR.
- IDLE/DONE/ERROR with i_start=1: pc, ptr and sp clear to 0; o_done and o_error clear; go to FETCH. The tape is not cleared.
- FETCH: if pc == i_prg_len, go to DONE. Otherwise latch i_prgmem_data into IR and go to EXEC.
- EXEC `+`/`-`: o_tape_we=1, o_tape_data = cell±1 modulo 2^TAPE_DW. pc+1.
- EXEC `>`/`<`: ptr±1 modulo 2^TAPE_AW. pc+1.
- EXEC `[`, cell≠0:
  - If sp == 2^STACK_AW-1 (stack full), go to ERROR.
  - Otherwise write pc+1 at address sp, sp+1, pc+1.
- EXEC `[`, cell==0: depth=1, pc+1, go to SKIP.
- EXEC `]` with sp==0: go to ERROR (underflow).
- EXEC `]`, cell≠0: stack read at address sp-1; pc=i_stack_data; sp unchanged.
- EXEC `]`, cell==0: sp-1 (pop), pc+1.
- SKIP: fetch one instruction per cycle.
  - `[` increments depth; `]` decrements depth. Depth counter is PRG_AW bits wide.
  - When `]` brings depth to 0: pc+1, go to FETCH.
  - If pc reaches i_prg_len while in SKIP: go to ERROR.
  - Stack, tape and ptr are untouched.
- EXEC `.`: latch the cell into o_out_data and go to OUT. OUT holds o_out_valid=1 until i_out_ready; on that cycle pc+1 and go to FETCH.
- EXEC `,`: go to IN. IN holds o_in_ready=1; on i_in_valid, o_tape_we=1 with o_tape_data=i_in_data, pc+1, go to FETCH.

## Timing
- Reset values:
  - State IDLE; pc, ptr, sp, IR and depth all 0.
  - All outputs 0: addresses, write enables, data, o_busy, o_done, o_error, o_out_valid, o_in_ready.
  - Write enables drop immediately when reset asserts, including mid-instruction.
- Instruction cost:
  - Simple instructions: 2 cycles (FETCH, EXEC).
  - I/O instructions: 2 cycles plus handshake wait, at least 1 cycle.
  - SKIP: 1 cycle per skipped instruction.
- Write enables are combinational from the state and are asserted only in EXEC or IN; the write commits on the next rising edge.
- o_busy=1 in FETCH, EXEC, OUT, IN and SKIP.
- o_done and o_error are sticky until i_start.
- o_out_data is stable while o_out_valid=1; o_out_valid never drops without i_out_ready.
- i_start arriving in the same cycle as a halt is ignored; it takes effect from the following cycle.

## Configuration
- BRAINHACK_IO_EN defined: `.`/`,` behave as above.
- BRAINHACK_IO_EN undefined:
  - `.`/`,` execute as NOPs (pc+1, 2 cycles).
  - o_out_valid, o_out_data and o_in_ready are tied to 0; the OUT/IN states are absent.
  - Ports remain present.

## Structure
- brainhack_pkg holds:
  - opcode localparams
  - state enumeration
  - shared instruction-width constant (3)
- Reuse the existing inc_dec for ptr, cell and sp arithmetic. The FSM, pc and depth counter stay in brainhack_core; no further sub-module.

## Test plan
- Program `+++` with i_prg_len=3, tape cell 0 = 0 → three writes of 1, 2, 3 to address 0; o_done after 6 cycles plus the halting FETCH.
- `-` on cell 0x00 → writes 0xFF; `<` at ptr 0 → ptr 0xFF.
- `[-]` with cell=3 → cell reaches 0, sp returns to 0, o_done=1, o_error=0.
- `[+[+]+]` with cell=0 → SKIP over 7 instructions, no tape/stack writes, o_done=1.
- `,.` with BRAINHACK_IO_EN, i_in_data=0x41, i_out_ready held low 5 cycles → o_out_valid=1 with o_out_data=0x41 stable for 5 cycles, then o_done.
- `]` as the first instruction → o_error=1 and no stack write. Then 16 nested `[` on a nonzero cell → o_error on the 16th. Then assert i_reset_n low mid-run → all outputs 0 immediately.
